// File: rtl/adam_block_sequencer.sv
// Adam block sequencer: turns one block read/write into SECTORS_PER_BLOCK flush/load/transfer passes on the sector loader.
// Latency: flush + load per sector; reads stream 1 byte per 2 cycles, writes 1 byte per cycle.
// Backpressure: rd_valid/rd_ready and wr_valid/wr_ready; ADAM_SEQ_SKIP_RELOAD_EN lets a read reuse the resident sector.
module adam_block_sequencer #(
  parameter int RETRY_CYCLES      = 4096,
  parameter int SECTORS_PER_BLOCK = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] req_block,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        disk_present,
  output logic [31:0] disk_sector,
  output logic        disk_load,
  input  logic        disk_sector_loaded,
  output logic [8:0]  disk_addr,
  output logic        disk_wr,
  output logic        disk_flush,
  input  logic        disk_error,
  output logic [7:0]  disk_din,
  input  logic [7:0]  disk_data
);
  localparam int          RW        = $clog2(RETRY_CYCLES + 1);
  localparam logic [31:0] SPB       = 32'(SECTORS_PER_BLOCK);
  localparam logic [1:0]  LAST_SIDX = 2'(SECTORS_PER_BLOCK - 1);

  typedef enum logic [2:0] {IDLE, FLUSH, LOAD, DROP, XFER, COMMIT, DONE} state_t;

  state_t        state;
  logic          op_wr;
  logic [31:0]   base;
  logic [31:0]   cur_sector;
  logic          cur_valid;
  logic [1:0]    sidx;
  logic [8:0]    cnt;
  logic [RW-1:0] retry;
  logic          fcnt;
  logic          dcnt;
  logic          err_acc;
  logic [31:0]   start_sector;
  logic          skip_start;
  logic          skip_next;

  assign start_sector = req_block * SPB;
  assign rd_data      = disk_data;

`ifdef ADAM_SEQ_SKIP_RELOAD_EN
  logic [31:0] next_sector;
  assign next_sector = base + 32'(sidx) + 32'd1;
  assign skip_start  = req_rd && cur_valid && (cur_sector == start_sector);
  assign skip_next   = !op_wr && cur_valid && (cur_sector == next_sector);
`else
  assign skip_start  = 1'b0;
  assign skip_next   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      rd_valid    <= 1'b0;
      wr_ready    <= 1'b0;
      disk_load   <= 1'b0;
      disk_wr     <= 1'b0;
      disk_flush  <= 1'b0;
      disk_sector <= '0;
      disk_addr   <= '0;
      disk_din    <= '0;
      cur_valid   <= 1'b0;
      cur_sector  <= '0;
      op_wr       <= 1'b0;
      base        <= '0;
      sidx        <= '0;
      cnt         <= '0;
      retry       <= '0;
      fcnt        <= 1'b0;
      dcnt        <= 1'b0;
      err_acc     <= 1'b0;
    end else begin
      done    <= 1'b0;
      disk_wr <= 1'b0;
      if (state != IDLE) err_acc <= err_acc | disk_error;
      case (state)
        IDLE: if (req_rd || req_wr) begin
          if ((req_rd && req_wr) || !disk_present) begin
            done  <= 1'b1;
            error <= 1'b1;
          end else begin
            op_wr   <= req_wr;
            base    <= start_sector;
            sidx    <= '0;
            busy    <= 1'b1;
            error   <= 1'b0;
            err_acc <= disk_error;
            if (skip_start) begin
              state       <= XFER;
              cnt         <= '0;
              disk_addr   <= '0;
              disk_sector <= start_sector;
            end else if (cur_valid) begin
              state <= FLUSH;
            end else begin
              state       <= LOAD;
              disk_load   <= 1'b1;
              disk_sector <= start_sector;
              retry       <= '0;
            end
          end
        end
        // First cycle raises flush; exit needs a second held cycle and the loader idle.
        FLUSH, COMMIT: begin
          if (!disk_flush) begin
            disk_flush  <= 1'b1;
            disk_sector <= cur_sector;
            fcnt        <= 1'b0;
          end else begin
            fcnt <= 1'b1;
            if (fcnt && !disk_sector_loaded) begin
              disk_flush <= 1'b0;
              if (state == FLUSH) begin
                state       <= LOAD;
                disk_load   <= 1'b1;
                disk_sector <= base + 32'(sidx);
                retry       <= '0;
              end else if (sidx == LAST_SIDX) begin
                state <= DONE;
              end else begin
                sidx  <= sidx + 2'd1;
                state <= skip_next ? XFER : FLUSH;
                cnt   <= '0;
              end
            end
          end
        end
        LOAD: begin
          if (disk_sector_loaded) begin
            disk_load  <= 1'b0;
            cur_sector <= disk_sector;
            cur_valid  <= 1'b1;
            cnt        <= '0;
            disk_addr  <= '0;
            rd_valid   <= 1'b0;
            wr_ready   <= op_wr;
            state      <= XFER;
          end else if (retry == RW'(RETRY_CYCLES - 1)) begin
            disk_load <= 1'b0;
            dcnt      <= 1'b0;
            state     <= DROP;
          end else begin
            retry <= retry + RW'(1);
          end
        end
        // Two low cycles on disk_load release a loader stuck after write-back.
        DROP: begin
          if (dcnt) begin
            disk_load <= 1'b1;
            retry     <= '0;
            state     <= LOAD;
          end else begin
            dcnt <= 1'b1;
          end
        end
        XFER: begin
          if (op_wr) begin
            if (wr_valid && wr_ready) begin
              disk_wr   <= 1'b1;
              disk_din  <= wr_data;
              disk_addr <= cnt;
              if (cnt == 9'd511) begin
                wr_ready <= 1'b0;
                state    <= COMMIT;
              end else begin
                cnt <= cnt + 9'd1;
              end
            end
          end else if (!rd_valid) begin
            rd_valid <= 1'b1;
          end else if (rd_ready) begin
            rd_valid <= 1'b0;
            if (cnt == 9'd511) begin
              if (sidx == LAST_SIDX) begin
                state <= DONE;
              end else begin
                sidx      <= sidx + 2'd1;
                state     <= skip_next ? XFER : FLUSH;
                cnt       <= '0;
                disk_addr <= '0;
              end
            end else begin
              cnt       <= cnt + 9'd1;
              disk_addr <= cnt + 9'd1;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          error <= err_acc | disk_error;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adam_block_sequencer.sv
// Directed bench for adam_block_sequencer with a behavioural sector loader.
module tb_adam_block_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_rd = 1'b0, req_wr = 1'b0;
  logic [31:0] req_block = '0;
  logic        busy, done, error;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic [7:0]  wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        disk_present = 1'b1;
  logic [31:0] disk_sector;
  logic        disk_load;
  logic        disk_sector_loaded;
  logic [8:0]  disk_addr;
  logic        disk_wr;
  logic        disk_flush;
  logic        disk_error = 1'b0;
  logic [7:0]  disk_din;
  logic [7:0]  disk_data = '0;

  always #5 clk = ~clk;

  adam_block_sequencer #(.RETRY_CYCLES(16), .SECTORS_PER_BLOCK(2)) dut (
    .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr), .req_block(req_block),
    .busy(busy), .done(done), .error(error), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .disk_present(disk_present), .disk_sector(disk_sector), .disk_load(disk_load),
    .disk_sector_loaded(disk_sector_loaded), .disk_addr(disk_addr), .disk_wr(disk_wr),
    .disk_flush(disk_flush), .disk_error(disk_error), .disk_din(disk_din), .disk_data(disk_data)
  );

  // Loader model: 4-cycle load, fills sector s with (s*7 + i); can refuse to load until a drop is seen.
  logic [7:0]  mem [0:511];
  logic        ld_loaded = 1'b0;
  logic [31:0] ld_sector = '1;
  logic [2:0]  ld_cnt = '0;
  logic        prev_load = 1'b0;
  int          drop_cnt = 0;
  int          stall_until = 0;

  assign disk_sector_loaded = ld_loaded && (disk_sector == ld_sector);

  always @(posedge clk) begin
    prev_load <= disk_load;
    if (prev_load && !disk_load && !disk_sector_loaded) drop_cnt <= drop_cnt + 1;
    if (disk_flush) begin
      ld_loaded <= 1'b0;
      ld_cnt    <= '0;
    end else if (disk_load && !disk_sector_loaded && drop_cnt >= stall_until) begin
      if (ld_cnt == 3'd3) begin
        ld_loaded <= 1'b1;
        ld_sector <= disk_sector;
        ld_cnt    <= '0;
        for (int i = 0; i < 512; i++) mem[i] <= 8'(disk_sector * 7 + 32'(i));
      end else begin
        ld_cnt <= ld_cnt + 3'd1;
      end
    end else if (!disk_load) begin
      ld_cnt <= '0;
    end
    if (disk_wr) mem[disk_addr] <= disk_din;
    disk_data <= mem[disk_addr];
  end

  // Observers, sampled mid-cycle.
  logic [31:0] load_log [0:63];
  logic [31:0] flush_log [0:63];
  int          low_log [0:63];
  int ld_n = 0, fl_n = 0, done_n = 0, wr_n = 0, wr_bad = 0, rx_n = 0, rd_bad = 0, both_n = 0, low_len = 0;
  int rx0 = 0, exp_base = 0;
  logic pl = 1'b0, pf = 1'b0;

  always @(negedge clk) begin
    int k, s;
    logic [7:0] e;
    if (disk_load && !pl) begin
      load_log[ld_n[5:0]] = disk_sector;
      low_log[ld_n[5:0]]  = low_len;
      ld_n++;
    end
    if (disk_load) low_len = 0; else low_len++;
    if (disk_flush && !pf) begin
      flush_log[fl_n[5:0]] = disk_sector;
      fl_n++;
    end
    pl = disk_load;
    pf = disk_flush;
    if (disk_load && disk_flush) both_n++;
    if (done) done_n++;
    if (disk_wr) begin
      wr_n++;
      if (disk_din !== disk_addr[7:0]) wr_bad++;
    end
    if (rd_valid && rd_ready) begin
      k = rx_n - rx0;
      s = exp_base + k / 512;
      e = 8'(s * 7 + k % 512);
      if (rd_data !== e) rd_bad++;
      rx_n++;
    end
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input logic rd, input logic wr, input logic [31:0] blk, input bit throttle,
                         input int err_at, input int abort_at, input int budget,
                         output bit got_done, output logic got_err, output int lat);
    int  k = 0;
    int  cyc = 0;
    bit  hs;
    step();
    req_rd = rd; req_wr = wr; req_block = blk;
    rx0 = rx_n; exp_base = int'(blk) * 2;
    step();
    req_rd = 1'b0; req_wr = 1'b0;
    got_done = 1'b0; got_err = 1'b0; lat = -1;
    while (!got_done && cyc < budget) begin
      wr_valid   = wr && (k < 1024);
      wr_data    = 8'(k);
      rd_ready   = !throttle || (cyc % 3 != 0);
      disk_error = (cyc == err_at);
      @(negedge clk);
      hs = wr_valid && wr_ready;
      if (done) begin
        got_done = 1'b1;
        got_err  = error;
        lat      = cyc;
      end
      step();
      if (hs) k++;
      cyc++;
      if (abort_at > 0 && rx_n - rx0 >= abort_at) break;
    end
    wr_valid = 1'b0; rd_ready = 1'b1; disk_error = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   d;
    logic er;
    int   lat, l0, f0, w0, r0, b0, d0;

    repeat (3) step();
    @(negedge clk);
    check("reset_ctl", 32'({busy, done, error, rd_valid, wr_ready, disk_load, disk_wr, disk_flush}), 32'd0);
    check("reset_sector", disk_sector, 32'd0);
    check("reset_addr_din", 32'({disk_addr, disk_din}), 32'd0);
    step();
    reset = 1'b0;

    // Read block 5: sectors 10, 11.
    l0 = ld_n; f0 = fl_n; r0 = rx_n; b0 = rd_bad;
    run_req(1'b1, 1'b0, 32'd5, 1'b0, -1, 0, 6000, d, er, lat);
    check("rd5_done", 32'(d), 32'd1);
    check("rd5_err", 32'(er), 32'd0);
    check("rd5_bytes", 32'(rx_n - r0), 32'd1024);
    check("rd5_data_bad", 32'(rd_bad - b0), 32'd0);
    check("rd5_loads", 32'(ld_n - l0), 32'd2);
    check("rd5_load0", load_log[l0[5:0]], 32'd10);
    check("rd5_load1", load_log[6'(l0 + 1)], 32'd11);
    check("rd5_flushes", 32'(fl_n - f0), 32'd1);
    check("rd5_flush0", flush_log[f0[5:0]], 32'd10);

    // Write block 3 with i & 0xFF: sectors 6, 7.
    l0 = ld_n; f0 = fl_n; w0 = wr_n; b0 = wr_bad;
    run_req(1'b0, 1'b1, 32'd3, 1'b0, -1, 0, 4000, d, er, lat);
    check("wr3_done", 32'(d), 32'd1);
    check("wr3_err", 32'(er), 32'd0);
    check("wr3_strobes", 32'(wr_n - w0), 32'd1024);
    check("wr3_data_bad", 32'(wr_bad - b0), 32'd0);
    check("wr3_flushes", 32'(fl_n - f0), 32'd4);
    check("wr3_flush_prev", flush_log[f0[5:0]], 32'd11);
    check("wr3_commit6", flush_log[6'(f0 + 1)], 32'd6);
    check("wr3_commit7", flush_log[6'(f0 + 3)], 32'd7);
    check("wr3_load0", load_log[l0[5:0]], 32'd6);
    check("wr3_load1", load_log[6'(l0 + 1)], 32'd7);

    // Loader stalls on the first load until disk_load is dropped; host throttles rd_ready.
    l0 = ld_n; r0 = rx_n; b0 = rd_bad; d0 = drop_cnt;
    stall_until = drop_cnt + 1;
    run_req(1'b1, 1'b0, 32'd5, 1'b1, -1, 0, 8000, d, er, lat);
    check("retry_done", 32'(d), 32'd1);
    check("retry_err", 32'(er), 32'd0);
    check("retry_drops", 32'(drop_cnt - d0), 32'd1);
    check("retry_loads", 32'(ld_n - l0), 32'd3);
    check("retry_reload", load_log[6'(l0 + 1)], 32'd10);
    check("retry_low_len", 32'(low_log[6'(l0 + 1)]), 32'd2);
    check("retry_load_next", load_log[6'(l0 + 2)], 32'd11);
    check("retry_bytes", 32'(rx_n - r0), 32'd1024);
    check("retry_data_bad", 32'(rd_bad - b0), 32'd0);

    // disk_error pulse mid-request is accumulated into error.
    r0 = rx_n; b0 = rd_bad;
    run_req(1'b1, 1'b0, 32'd1, 1'b0, 300, 0, 6000, d, er, lat);
    check("err_done", 32'(d), 32'd1);
    check("err_flag", 32'(er), 32'd1);
    check("err_data_bad", 32'(rd_bad - b0), 32'd0);

    // Illegal request: read and write together.
    l0 = ld_n; f0 = fl_n;
    run_req(1'b1, 1'b1, 32'd9, 1'b0, -1, 0, 4, d, er, lat);
    check("both_done_lat", 32'(lat), 32'd0);
    check("both_err", 32'(er), 32'd1);
    check("both_no_disk", 32'((ld_n - l0) + (fl_n - f0)), 32'd0);

    // No disk present.
    disk_present = 1'b0;
    run_req(1'b1, 1'b0, 32'd9, 1'b0, -1, 0, 4, d, er, lat);
    disk_present = 1'b1;
    check("nodisk_done_lat", 32'(lat), 32'd0);
    check("nodisk_err", 32'(er), 32'd1);
    check("nodisk_no_load", 32'(ld_n - l0), 32'd0);

    // Reset mid-transfer at byte 200, then a fresh read of block 2.
    d0 = done_n;
    run_req(1'b1, 1'b0, 32'd5, 1'b0, -1, 200, 6000, d, er, lat);
    check("abort_reached", 32'(rx_n - rx0), 32'd200);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ctl", 32'({busy, done, error, rd_valid, wr_ready, disk_load, disk_wr, disk_flush}), 32'd0);
    check("midrst_sector", disk_sector, 32'd0);
    check("midrst_addr_din", 32'({disk_addr, disk_din}), 32'd0);
    repeat (20) step();
    check("midrst_no_done", 32'(done_n - d0), 32'd0);
    l0 = ld_n; f0 = fl_n; r0 = rx_n; b0 = rd_bad;
    run_req(1'b1, 1'b0, 32'd2, 1'b0, -1, 0, 6000, d, er, lat);
    check("post_done", 32'(d), 32'd1);
    check("post_err", 32'(er), 32'd0);
    check("post_load0", load_log[l0[5:0]], 32'd4);
    check("post_flushes", 32'(fl_n - f0), 32'd1);
    check("post_bytes", 32'(rx_n - r0), 32'd1024);
    check("post_data_bad", 32'(rd_bad - b0), 32'd0);

    check("load_flush_overlap", 32'(both_n), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
